// File: rtl/voice_mixer_if.sv
// voice_mixer_if: voice-side inputs and codec-side outputs of the voice mixer.
interface voice_mixer_if #(
    parameter int NUM_VOICES = 3,
    parameter int SAMPLE_W   = 16,
    parameter int GAIN_W     = 4
);
    logic [NUM_VOICES*SAMPLE_W-1:0] voice_sample;
    logic [NUM_VOICES-1:0]          voice_ready;
    logic [NUM_VOICES-1:0]          voice_mute;
    logic [NUM_VOICES*GAIN_W-1:0]   voice_gain;
    logic                           mode;
    logic [SAMPLE_W-1:0]            sample_out;
    logic                           new_sample_ready;
    logic                           clip;
    logic                           late;

    modport master (
        output voice_sample, voice_ready, voice_mute, voice_gain, mode,
        input  sample_out, new_sample_ready, clip, late
    );

    modport slave (
        input  voice_sample, voice_ready, voice_mute, voice_gain, mode,
        output sample_out, new_sample_ready, clip, late
    );
endinterface

// File: rtl/voice_mixer.sv
// voice_mixer: aligns one sample per voice into a frame, applies per-voice gain
// and mute, accumulates serially (one voice per cycle) and emits one limited
// mixed sample per frame. Stalled voices are dropped after TIMEOUT cycles.
module voice_mixer #(
    parameter int NUM_VOICES = 3,
    parameter int SAMPLE_W   = 16,
    parameter int GAIN_W     = 4,
    parameter int TIMEOUT    = 255
) (
    input logic          clk,
    input logic          reset,
    voice_mixer_if.slave bus
);
    localparam int LOG_N      = $clog2(NUM_VOICES);
    localparam int IDX_W      = (NUM_VOICES > 1) ? LOG_N : 1;
    localparam int PROD_W     = SAMPLE_W + GAIN_W + 1;
    localparam int ACC_W      = PROD_W + LOG_N;
    localparam int SHIFT_SAT  = GAIN_W - 1;
    localparam int SHIFT_NORM = GAIN_W - 1 + LOG_N;
    localparam int CNT_W      = 16;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_SUM     = 2'd2,
        ST_OUT     = 2'd3
    } state_t;

    state_t                     r_state;
    logic [CNT_W-1:0]           r_cnt;
    logic [IDX_W-1:0]           r_idx;
    logic signed [ACC_W-1:0]    r_acc;
    logic                       r_mode;
    logic                       r_late_pend;
    logic [NUM_VOICES-1:0]      r_pending;
    logic [NUM_VOICES-1:0]      r_mask;
    logic signed [SAMPLE_W-1:0] r_cap    [NUM_VOICES];
    logic signed [SAMPLE_W-1:0] r_work_s [NUM_VOICES];
    logic [GAIN_W-1:0]          r_work_g [NUM_VOICES];
    logic [SAMPLE_W-1:0]        r_sample_out;
    logic                       r_nsr;
    logic                       r_clip;
    logic                       r_late;

    logic signed [SAMPLE_W-1:0] w_in_s [NUM_VOICES];
    logic [GAIN_W-1:0]          w_in_g [NUM_VOICES];
    logic [NUM_VOICES-1:0]      w_rdy;
    logic [NUM_VOICES-1:0]      w_pend_now;
    logic [NUM_VOICES-1:0]      w_live;
    logic [NUM_VOICES-1:0]      w_fresh;
    logic [NUM_VOICES-1:0]      w_pending_nxt;
    logic                       w_complete;
    logic                       w_timeout;
    logic                       w_enter_sum;
    logic                       w_late_now;
    logic signed [SAMPLE_W-1:0] w_cur_s;
    logic [GAIN_W-1:0]          w_cur_g;
    logic signed [PROD_W-1:0]   w_prod;
    logic signed [ACC_W-1:0]    w_term;
    logic signed [ACC_W-1:0]    w_acc_sum;
    logic signed [ACC_W-1:0]    w_shifted;
    logic signed [SAMPLE_W-1:0] w_sat;
    logic                       w_clip;

    // Split the flattened voice buses into per-voice views.
    always_comb begin
        for (int i = 0; i < NUM_VOICES; i++) begin
            w_in_s[i] = bus.voice_sample[i*SAMPLE_W +: SAMPLE_W];
            w_in_g[i] = bus.voice_gain[i*GAIN_W +: GAIN_W];
        end
    end

    // A pulse arriving this cycle already counts toward completing the frame.
    assign w_rdy      = bus.voice_ready & ~bus.voice_mute;
    assign w_pend_now = r_pending | w_rdy;
    assign w_live     = w_pend_now & ~bus.voice_mute;
    assign w_fresh    = w_rdy & ~r_pending;
    assign w_complete = &(w_pend_now | bus.voice_mute);
    assign w_timeout  = (r_state == ST_COLLECT) && (r_cnt == CNT_LAST);

    // Decide when the current frame closes and whether it closed by timeout.
    always_comb begin
        w_enter_sum = 1'b0;
        w_late_now  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if ((|w_live) && w_complete) begin
                    w_enter_sum = 1'b1;
                end else begin
                    w_enter_sum = 1'b0;
                end
            end
            ST_COLLECT: begin
                if (w_complete) begin
                    w_enter_sum = 1'b1;
                end else if (w_timeout) begin
                    w_enter_sum = 1'b1;
                    w_late_now  = 1'b1;
                end else begin
                    w_enter_sum = 1'b0;
                end
            end
            default: begin
                w_enter_sum = 1'b0;
                w_late_now  = 1'b0;
            end
        endcase
    end

    // Closing a frame releases its pending bits; a repeat pulse from an
    // already-pending voice in that cycle stays pending for the next frame.
    assign w_pending_nxt = w_enter_sum ? (w_rdy & r_pending) : w_pend_now;

    // Multiply-accumulate the voice selected by r_idx, then scale and limit.
    always_comb begin
        w_cur_s   = r_work_s[r_idx];
        w_cur_g   = r_work_g[r_idx];
        w_prod    = PROD_W'(w_cur_s) * $signed(PROD_W'(w_cur_g));
        if (r_mask[r_idx]) begin
            w_term = ACC_W'(w_prod);
        end else begin
            w_term = {ACC_W{1'b0}};
        end
        w_acc_sum = r_acc + w_term;
        if (r_mode) begin
            w_shifted = w_acc_sum >>> SHIFT_SAT;
        end else begin
            w_shifted = w_acc_sum >>> SHIFT_NORM;
        end
        if (w_shifted > SAT_MAX) begin
            w_sat  = SAT_MAX[SAMPLE_W-1:0];
            w_clip = 1'b1;
        end else if (w_shifted < SAT_MIN) begin
            w_sat  = SAT_MIN[SAMPLE_W-1:0];
            w_clip = 1'b1;
        end else begin
            w_sat  = w_shifted[SAMPLE_W-1:0];
            w_clip = 1'b0;
        end
    end

    // Frame sequencing, capture bank, serial accumulation and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= {CNT_W{1'b0}};
            r_idx        <= {IDX_W{1'b0}};
            r_acc        <= {ACC_W{1'b0}};
            r_mode       <= 1'b0;
            r_late_pend  <= 1'b0;
            r_pending    <= {NUM_VOICES{1'b0}};
            r_mask       <= {NUM_VOICES{1'b0}};
            r_sample_out <= {SAMPLE_W{1'b0}};
            r_nsr        <= 1'b0;
            r_clip       <= 1'b0;
            r_late       <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_cap[i]    <= {SAMPLE_W{1'b0}};
                r_work_s[i] <= {SAMPLE_W{1'b0}};
                r_work_g[i] <= {GAIN_W{1'b0}};
            end
        end else begin
            r_pending <= w_pending_nxt;
            r_nsr     <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (w_rdy[i]) begin
                    r_cap[i] <= w_in_s[i];
                end
            end
            if (w_enter_sum) begin
                for (int i = 0; i < NUM_VOICES; i++) begin
                    r_work_s[i] <= w_fresh[i] ? w_in_s[i] : r_cap[i];
                    r_work_g[i] <= w_in_g[i];
                end
                r_mask      <= w_live;
                r_acc       <= {ACC_W{1'b0}};
                r_idx       <= {IDX_W{1'b0}};
                r_mode      <= bus.mode;
                r_late_pend <= w_late_now;
            end
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= {CNT_W{1'b0}};
                    if (w_enter_sum) begin
                        r_state <= ST_SUM;
                    end else if (|w_live) begin
                        r_state <= ST_COLLECT;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_COLLECT: begin
                    if (w_enter_sum) begin
                        r_state <= ST_SUM;
                        r_cnt   <= {CNT_W{1'b0}};
                    end else begin
                        r_cnt   <= r_cnt + CNT_W'(1'b1);
                    end
                end
                ST_SUM: begin
                    r_acc <= w_acc_sum;
                    if (r_idx == LAST_IDX) begin
                        r_idx        <= {IDX_W{1'b0}};
                        r_sample_out <= w_sat;
                        r_clip       <= w_clip;
                        r_late       <= r_late_pend;
                        r_nsr        <= 1'b1;
                        r_state      <= ST_OUT;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1'b1);
                    end
                end
                ST_OUT: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.sample_out       = r_sample_out;
    assign bus.new_sample_ready = r_nsr;
    assign bus.clip             = r_clip;
    assign bus.late             = r_late;
endmodule

// File: tb/tb_voice_mixer.sv
// tb_voice_mixer: randomized and directed frames, expected mixes from a
// frame-level arithmetic model queued on issue and checked by a monitor.
module tb_voice_mixer;
    localparam int NV = 3;
    localparam int SW = 16;
    localparam int GW = 4;
    localparam int TO = 16;

    typedef struct {
        int value;
        bit clip;
        bit late;
        int cyc;
    } exp_t;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   pulse_count = 0;
    exp_t q[$];

    int f_s [NV];
    int f_g [NV];
    bit f_m [NV];
    int f_d [NV];
    bit f_md;

    voice_mixer_if #(.NUM_VOICES(NV), .SAMPLE_W(SW), .GAIN_W(GW)) bus ();

    voice_mixer #(.NUM_VOICES(NV), .SAMPLE_W(SW), .GAIN_W(GW), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index: inputs driven while cyc==K are sampled at the edge ending cycle K.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog cycle=%0d", cyc);
        $fatal(1);
    end

    function automatic void chk(input string name, input logic signed [31:0] act,
                                input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference: weighted sum of included voices, scaled, limited to the sample range.
    function automatic void mix_model(input int s[NV], input int g[NV], input bit inc[NV],
                                      input bit md, output int val, output bit clp);
        longint acc;
        longint maxv;
        longint minv;
        int     sh;
        acc  = 0;
        maxv = (longint'(1) <<< (SW - 1)) - 1;
        minv = -(longint'(1) <<< (SW - 1));
        sh   = GW - 1 + (md ? 0 : $clog2(NV));
        for (int i = 0; i < NV; i++)
            if (inc[i]) acc += longint'(s[i]) * longint'(g[i]);
        acc = acc >>> sh;
        clp = 1'b0;
        if (acc > maxv) begin
            acc = maxv;
            clp = 1'b1;
        end else if (acc < minv) begin
            acc = minv;
            clp = 1'b1;
        end
        val = int'(acc);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int v, input bit c, input bit l, input int when);
        exp_t e;
        e.value = v;
        e.clip  = c;
        e.late  = l;
        e.cyc   = when;
        q.push_back(e);
    endtask

    task automatic set_cfg();
        for (int i = 0; i < NV; i++) begin
            bus.voice_gain[i*GW +: GW] = f_g[i][GW-1:0];
            bus.voice_mute[i]          = f_m[i];
        end
        bus.mode = f_md;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 400) begin
            tick();
            n++;
        end
        if (q.size() != 0) begin
            chk("drain_timeout", q.size(), 0);
            q.delete();
        end
        tick();
    endtask

    // Drive one frame from f_* (delay -1 = voice never pulses) and queue its expectation.
    task automatic run_frame();
        int t0, dmax, dall, v;
        bit missing, c;
        bit inc [NV];
        dmax = 0;
        dall = 0;
        missing = 1'b0;
        for (int i = 0; i < NV; i++) begin
            inc[i] = !f_m[i] && (f_d[i] >= 0);
            if (!f_m[i] && f_d[i] < 0) missing = 1'b1;
            if (!f_m[i] && f_d[i] > dmax) dmax = f_d[i];
            if (f_d[i] > dall) dall = f_d[i];
        end
        set_cfg();
        t0 = cyc;
        mix_model(f_s, f_g, inc, f_md, v, c);
        push_exp(v, c, missing, (missing ? t0 + TO : t0 + dmax) + NV + 1);
        for (int k = 0; k <= dall; k++) begin
            for (int i = 0; i < NV; i++) begin
                bus.voice_ready[i] = (f_d[i] == k);
                if (f_d[i] == k) bus.voice_sample[i*SW +: SW] = f_s[i][SW-1:0];
            end
            tick();
        end
        bus.voice_ready = {NV{1'b0}};
        wait_drain();
    endtask

    // Monitor: every output pulse must match the oldest queued expectation.
    initial begin
        exp_t e;
        bit   prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.new_sample_ready === 1'b1) begin
                pulse_count++;
                chk("back_to_back", prev, 0);
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse actual=%0d required=no pulse (cycle %0d)",
                             $signed(bus.sample_out), cyc);
                end else begin
                    e = q.pop_front();
                    chk("sample_out", $signed(bus.sample_out), e.value);
                    chk("clip", bus.clip, e.clip);
                    chk("late", bus.late, e.late);
                    chk("pulse_cycle", cyc, e.cyc);
                end
            end
            prev = (bus.new_sample_ready === 1'b1);
        end
    end

    initial begin
        int t0, p0, p, v;
        bit c, done, allm;
        bit inc [NV];

        reset = 1'b0;
        bus.voice_sample = {(NV*SW){1'b0}};
        bus.voice_ready  = {NV{1'b0}};
        bus.voice_mute   = {NV{1'b0}};
        bus.voice_gain   = {(NV*GW){1'b0}};
        bus.mode         = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_sample_out", $signed(bus.sample_out), 0);
        chk("rst_nsr", bus.new_sample_ready, 0);
        chk("rst_clip", bus.clip, 0);
        chk("rst_late", bus.late, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick();

        // Simultaneous and staggered frames.
        f_s = '{1000, 2000, -600}; f_g = '{8, 8, 8}; f_m = '{0, 0, 0}; f_md = 1'b0;
        f_d = '{0, 0, 0};
        run_frame();
        f_d = '{0, 5, 9};
        run_frame();

        // Saturation in both directions.
        f_md = 1'b1; f_g = '{15, 15, 15}; f_d = '{0, 0, 0};
        f_s = '{30000, 30000, 30000};
        run_frame();
        f_s = '{-30000, -30000, -30000};
        run_frame();

        // Reset while summing: frame aborted, outputs cleared, no pulse.
        f_s = '{100, 200, 300}; f_g = '{8, 8, 8}; f_md = 1'b0;
        set_cfg();
        for (int i = 0; i < NV; i++) bus.voice_sample[i*SW +: SW] = f_s[i][SW-1:0];
        bus.voice_ready = {NV{1'b1}};
        tick();
        bus.voice_ready = {NV{1'b0}};
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_sample_out", $signed(bus.sample_out), 0);
        chk("midrst_clip", bus.clip, 0);
        chk("midrst_late", bus.late, 0);
        chk("midrst_nsr", bus.new_sample_ready, 0);
        p0 = pulse_count;
        repeat (12) tick();
        chk("midrst_no_pulse", pulse_count - p0, 0);

        // Timeout with voice 2 silent.
        f_s = '{4000, 4000, 0}; f_g = '{8, 8, 8}; f_m = '{0, 0, 0}; f_md = 1'b0;
        f_d = '{0, 0, -1};
        run_frame();

        // Muting the silent voice mid-collect closes the frame at once.
        set_cfg();
        t0 = cyc;
        bus.voice_sample[0*SW +: SW] = 16'sd4000;
        bus.voice_sample[1*SW +: SW] = 16'sd4000;
        bus.voice_ready = 3'b011;
        push_exp(2000, 1'b0, 1'b0, t0 + 5 + NV + 1);
        tick();
        bus.voice_ready = {NV{1'b0}};
        repeat (4) tick();
        bus.voice_mute = 3'b100;
        wait_drain();
        bus.voice_mute = {NV{1'b0}};
        tick();

        // Pulse during SUM belongs to the next frame.
        f_s = '{1000, 2000, -600};
        set_cfg();
        t0 = cyc;
        for (int i = 0; i < NV; i++) bus.voice_sample[i*SW +: SW] = f_s[i][SW-1:0];
        bus.voice_ready = {NV{1'b1}};
        push_exp(600, 1'b0, 1'b0, t0 + NV + 1);
        tick();
        bus.voice_ready = {NV{1'b0}};
        tick();
        bus.voice_sample[0*SW +: SW] = 16'sd1200;
        bus.voice_ready = 3'b001;
        tick();
        bus.voice_ready = {NV{1'b0}};
        repeat (5) tick();
        f_s = '{1200, 2000, 3000};
        inc = '{1, 1, 1};
        mix_model(f_s, f_g, inc, 1'b0, v, c);
        bus.voice_sample[1*SW +: SW] = 16'sd2000;
        bus.voice_sample[2*SW +: SW] = 16'sd3000;
        bus.voice_ready = 3'b110;
        push_exp(v, c, 1'b0, t0 + 8 + NV + 1);
        tick();
        bus.voice_ready = {NV{1'b0}};
        wait_drain();

        // Randomized frames: random samples, gains, mutes, mode, arrival order, stalls.
        for (int f = 0; f < 40; f++) begin
            allm = 1'b1;
            for (int i = 0; i < NV; i++) begin
                f_s[i] = int'($urandom_range(65535, 0)) - 32768;
                f_g[i] = int'($urandom_range(15, 0));
                f_m[i] = ($urandom_range(3, 0) == 0);
                f_d[i] = int'($urandom_range(12, 0));
                if (!f_m[i]) allm = 1'b0;
            end
            if (allm) f_m[0] = 1'b0;
            p = -1;
            for (int i = 0; i < NV; i++) if (!f_m[i] && p < 0) p = i;
            f_d[p] = 0;
            if ($urandom_range(5, 0) == 0) begin
                done = 1'b0;
                for (int i = 0; i < NV; i++) begin
                    if (!done && !f_m[i] && i != p) begin
                        f_d[i] = -1;
                        done = 1'b1;
                    end
                end
            end
            f_md = 1'(($urandom_range(1, 0)));
            run_frame();
        end

        // All voices muted with toggling readies: no output for 1000 cycles.
        bus.voice_mute = {NV{1'b1}};
        p0 = pulse_count;
        for (int k = 0; k < 1000; k++) begin
            bus.voice_ready  = NV'($urandom_range(7, 0));
            bus.voice_sample = (NV*SW)'({$urandom(), $urandom()});
            tick();
        end
        bus.voice_ready = {NV{1'b0}};
        tick();
        chk("muted_no_output", pulse_count - p0, 0);
        bus.voice_mute = {NV{1'b0}};
        repeat (4) tick();

        wait_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/voice_mixer.md
# voice_mixer

Parametrised N-voice mixer that collects one sample from each `note_player` voice, scales each by a per-voice gain, and emits one combined sample per frame to the codec interface. It sits between the voice array and the codec, replacing fixed three-voice summing. It adds per-voice gain and mute, frame alignment of unsynchronised voice ready pulses, a selectable normalise/saturate mode, and a timeout for stalled voices.

## Interface
- NUM_VOICES, 3, number of voice channels (1..16)
- SAMPLE_W, 16, signed sample width
- GAIN_W, 4, unsigned gain width; gain value 2^(GAIN_W-1) = unity (Q1.(GAIN_W-1))
- TIMEOUT, 255, max cycles spent collecting a frame (2..2^16-1)
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset (0 = reset)
- voice_sample  in  NUM_VOICES*SAMPLE_W  signed samples; voice i at [i*SAMPLE_W +: SAMPLE_W]
- voice_ready  in  NUM_VOICES  one-cycle pulse per voice: sample i valid this cycle
- voice_mute  in  NUM_VOICES  1 = voice i contributes 0 and is not waited for
- voice_gain  in  NUM_VOICES*GAIN_W  per-voice gain; voice i at [i*GAIN_W +: GAIN_W]
- mode  in  1  0 = NORMALIZE, 1 = SATURATE; sampled on entry to SUM
- sample_out  out  SAMPLE_W  mixed sample; holds its value between frames
- new_sample_ready  out  1  one-cycle pulse, sample_out valid
- clip  out  1  valid with new_sample_ready; 1 = saturation applied
- late  out  1  valid with new_sample_ready; 1 = frame closed by timeout

## Operation
- Capture bank: per voice, a sample register and a pending bit. An unmuted voice_ready[i] loads sample i and sets pending[i] in any state. A repeat pulse overwrites the sample. Ready pulses from muted voices are ignored.
- Frame is complete when every voice is pending or muted. Mute is evaluated each cycle, so muting a voice mid-frame completes it.
- States: IDLE, COLLECT, SUM, OUT.
- IDLE: if any pending bit is set, go to COLLECT. If the frame is already complete, go directly to SUM. All muted: stay in IDLE, no output.
- COLLECT: timeout counter starts at 0 and increments each cycle. Go to SUM when complete, or when counter = TIMEOUT-1. In the timeout case, set late; missing voices contribute 0.
- SUM entry: copy capture samples, gains and the pending-and-unmuted mask to working registers. Clear all pending bits in the same edge; ready pulses in that same cycle are kept for the next frame. Clear accumulator; latch mode.
- SUM: one voice per cycle, i = 0..NUM_VOICES-1. acc += sample_i * gain_i if the mask bit is set, else +0.
  - Product: signed SAMPLE_W+GAIN_W+1 bits (gain zero-extended).
  - Accumulator: SAMPLE_W+GAIN_W+1+clog2(NUM_VOICES) bits.
- After the last voice, arithmetic shift right by GAIN_W-1. NORMALIZE additionally shifts right by clog2(NUM_VOICES).
- Result is saturated to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1] in both modes; clip=1 if limiting occurred.
- OUT: register sample_out, clip and late; pulse new_sample_ready; go to IDLE.

## Timing
- Reset (reset=0 at an edge): state IDLE; sample_out=0, new_sample_ready=0, clip=0, late=0; pending, accumulator and counter cleared.
- Reset mid-frame aborts the frame with no output pulse.
- Latency: a frame completes in cycle c (or times out). SUM runs cycles c+1..c+NUM_VOICES. new_sample_ready is high in cycle c+NUM_VOICES+1 (4 cycles for NUM_VOICES=3).
- new_sample_ready is never high two cycles in a row. Minimum frame spacing is NUM_VOICES+2 cycles.
- Ready pulses arriving in SUM or OUT belong to the next frame and are never lost.

## Test plan
- Simultaneous frame: NUM_VOICES=3, mode=0, gains 8. Samples 1000, 2000, -600 pulsed in cycle 0 -> single pulse in cycle 4, sample_out=600, clip=0, late=0.
- Staggered frame: readies in cycles 0, 5, 9 -> exactly one new_sample_ready, in cycle 13, same value 600.
- Saturation: mode=1, gains 15, samples 30000 x3 -> sample_out=32767, clip=1. Samples -30000 x3 -> sample_out=-32768, clip=1.
- Timeout: TIMEOUT=16, voice 2 never pulses, voices 0/1 give 4000/4000 with gain 8, mode=0 -> pulse after timeout, sample_out=2000, late=1. Muting voice 2 mid-COLLECT instead closes the frame immediately with late=0.
- Overlap: voice 0 pulses 1200 during SUM -> current frame is unaffected; next frame includes 1200 with no loss.
- Reset and mute: reset=0 during SUM -> no pulse, all outputs 0. All voices muted with readies toggling -> no new_sample_ready for 1000 cycles.
